// File: rtl/audio_tdm_master_if.sv
// Halfword write channel from the endpoint data mover into the audio output FIFO.
interface audio_tdm_master_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/audio_tdm_master.sv
// Serial audio master: buffers halfwords in a FIFO and serialises them as
// I2S, left-justified or TDM (DSP mode A) frames with a divided bit clock.
// A frame only starts when a whole frame of data is buffered; otherwise an
// all-zero frame is sent and the sticky underrun flag is raised.
module audio_tdm_master #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [1:0]                  word_size,
  input  logic [DIV_W-1:0]            sck_div,
  audio_tdm_master_if.slave           in_bus,
  input  logic                        clr_underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        underrun,
  output logic                        aud_sck,
  output logic                        aud_ws,
  output logic                        aud_sd
);

  localparam int LW  = $clog2(FIFO_DEPTH);
  localparam int LVW = LW + 1;
  localparam int BW  = $clog2(CHANNELS * 32) + 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t           state;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    rd_ptr1;
  logic             push;
  logic [1:0]       pop_n;

  logic [1:0]       mode_q;
  logic [1:0]       wsz_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic             half;
  logic             zero_frame;
  logic [BW-1:0]    bit_idx;
  logic [BW-1:0]    nxt_idx;
  logic [BW-1:0]    fb;
  logic [BW-1:0]    fb_m1;
  logic [BW-1:0]    half_fb;
  logic [LVW-1:0]   hf;
  logic [31:0]      shreg;
  logic [31:0]      load_word;
  logic             sw16;
  logic             last_in_slot;
  logic             bit_end;
  logic             frame_end;
  logic             frame_ok;
  logic             load_pop;
  logic             ws_next;

  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign in_bus.in_ready = (fifo_level != LVW'(FIFO_DEPTH));
  assign busy            = (state != IDLE);
  assign rd_ptr1         = rd_ptr + LW'(1);

  assign sw16         = (wsz_q == 2'b00);
  assign fb           = sw16 ? BW'(CHANNELS * 16) : BW'(CHANNELS * 32);
  assign fb_m1        = fb - BW'(1);
  assign half_fb      = fb >> 1;
  assign hf           = sw16 ? LVW'(CHANNELS) : LVW'(2 * CHANNELS);
  assign frame_ok     = (fifo_level >= hf);
  assign last_in_slot = sw16 ? (&bit_idx[3:0]) : (&bit_idx[4:0]);
  assign bit_end      = (state == RUN) && half && (div_cnt == div_q);
  assign frame_end    = bit_end && (bit_idx == fb_m1);
  assign nxt_idx      = ((state == RUN) && !frame_end) ? bit_idx + BW'(1) : '0;

  // Frame-sync level for the bit about to start, in the latched framing mode.
  always_comb begin
    ws_next = 1'b0;
    case (mode_q)
      2'b01:   ws_next = (nxt_idx >= half_fb);
      2'b10:   ws_next = (nxt_idx == fb_m1);
      default: ws_next = (nxt_idx != fb_m1) && ((nxt_idx + BW'(1)) >= half_fb);
    endcase
  end

  // Slot word assembled from the FIFO head: 16-bit, 24-bit left-aligned, or 32-bit.
  always_comb begin
    load_word = 32'h0;
    if (sw16)
      load_word = {mem[rd_ptr], 16'h0000};
    else if (wsz_q == 2'b01)
      load_word = {mem[rd_ptr], mem[rd_ptr1][15:8], 8'h00};
    else
      load_word = {mem[rd_ptr], mem[rd_ptr1]};
  end

  // Pops happen only when a checked frame starts or a data-carrying slot begins.
  always_comb begin
    load_pop = 1'b0;
    if (state == ARM)
      load_pop = en && frame_ok;
    else if (frame_end)
      load_pop = en && frame_ok;
    else if (bit_end)
      load_pop = last_in_slot && !zero_frame;
    pop_n = load_pop ? (sw16 ? 2'd1 : 2'd2) : 2'd0;
  end

  // FIFO storage write; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_bus.in_data;
  end

  // FIFO pointers and level; a push and pop in the same cycle cancel in the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + LW'(push);
      rd_ptr     <= rd_ptr + LW'(pop_n);
      fifo_level <= fifo_level + LVW'(push) - LVW'(pop_n);
    end
  end

  // Sequencer: config latch, bit clock divider, frame checks and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 2'b00;
      wsz_q      <= 2'b00;
      div_q      <= '0;
      div_cnt    <= '0;
      half       <= 1'b0;
      zero_frame <= 1'b0;
      bit_idx    <= '0;
      shreg      <= 32'h0;
      underrun   <= 1'b0;
      aud_sck    <= 1'b0;
      aud_ws     <= 1'b0;
      aud_sd     <= 1'b0;
    end else begin
      if (clr_underrun)
        underrun <= 1'b0;
      case (state)
        IDLE: begin
          aud_sck <= 1'b0;
          aud_ws  <= 1'b0;
          aud_sd  <= 1'b0;
          if (en) begin
            mode_q <= mode;
            wsz_q  <= word_size;
            div_q  <= sck_div;
            state  <= ARM;
          end
        end
        ARM: begin
          if (!en) begin
            state <= IDLE;
          end else if (frame_ok) begin
            state      <= RUN;
            bit_idx    <= '0;
            half       <= 1'b0;
            div_cnt    <= '0;
            zero_frame <= 1'b0;
            shreg      <= load_word;
            aud_sd     <= load_word[31];
            aud_ws     <= ws_next;
            aud_sck    <= 1'b0;
          end
        end
        RUN: begin
          if (div_cnt != div_q) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!half) begin
              half    <= 1'b1;
              aud_sck <= 1'b1;
            end else begin
              half    <= 1'b0;
              aud_sck <= 1'b0;
              if (bit_idx == fb_m1) begin
                bit_idx <= '0;
                if (!en) begin
                  state  <= IDLE;
                  aud_ws <= 1'b0;
                  aud_sd <= 1'b0;
                end else if (frame_ok) begin
                  zero_frame <= 1'b0;
                  shreg      <= load_word;
                  aud_sd     <= load_word[31];
                  aud_ws     <= ws_next;
                end else begin
                  zero_frame <= 1'b1;
                  underrun   <= 1'b1;
                  shreg      <= 32'h0;
                  aud_sd     <= 1'b0;
                  aud_ws     <= ws_next;
                end
              end else begin
                bit_idx <= bit_idx + BW'(1);
                aud_ws  <= ws_next;
                if (last_in_slot) begin
                  if (zero_frame) begin
                    shreg  <= 32'h0;
                    aud_sd <= 1'b0;
                  end else begin
                    shreg  <= load_word;
                    aud_sd <= load_word[31];
                  end
                end else begin
                  shreg  <= {shreg[30:0], 1'b0};
                  aud_sd <= shreg[30];
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
